bip_control_unit: RTL and testbench
===================================

Name: bip_control_unit

Overview:
Parametrised next-generation control unit for the BIP accumulator processor. It holds the program counter, fetches from instruction memory with a valid handshake, decodes an extended ISA (arithmetic, logic and conditional branches), and drives the datapath and data-RAM strobes. It sits between program memory and the accumulator/ALU datapath. It adds halt and illegal-opcode handling and a retired-instruction counter.

Parameters:
INSTR_W, 16, instruction width; opcode is the top OPC_W bits and the operand is the remainder.
OPC_W, 5, opcode field width.
ADDR_W, 11, program-counter and data-address width; requires ADDR_W <= INSTR_W-OPC_W.
CNT_W, 16, width of the retired-instruction counter.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Instruction  in  INSTR_W  instruction word at address Addr.
InstrValid  in  1  Instruction is valid this cycle.
Zero  in  1  accumulator == 0, from the datapath.
Neg  in  1  accumulator MSB, from the datapath.
Addr  out  ADDR_W  program counter, registered.
Operand  out  INSTR_W-OPC_W  operand field, passed through combinationally.
SelA  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU.
SelB  out  1  ALU B source: 0 RAM, 1 immediate.
Op  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
WrAcc  out  1  write accumulator.
WrRam  out  1  write data RAM at Operand.
RdRam  out  1  read data RAM at Operand.
Halted  out  1  core stopped.
IllegalOp  out  1  sticky flag: an illegal opcode was executed.
RetCount  out  CNT_W  count of retired instructions; wraps.

Behaviour:
- Reset (sampled at the clock edge): Addr=0, state=RUN, Halted=0, IllegalOp=0, RetCount=0. While Reset=1, all strobes (WrAcc, WrRam, RdRam) are 0, and SelA/SelB/Op are 0.
- States: RUN and HALT. RUN goes to HALT when HLT executes. HALT exits only on Reset.
- An instruction executes when state=RUN and InstrValid=1. Decode is combinational, and strobes are valid in the same cycle. Addr and RetCount update at the next edge.
- If InstrValid=0 in RUN: all strobes are 0, Addr holds, RetCount holds.
- In HALT: all strobes are 0, Addr holds, Halted=1. InstrValid is ignored.
- Opcode map. Every control output not listed below is 0.
  - 00000 HLT: no strobes.
  - 00001 STO: WrRam.
  - 00010 LD: RdRam, WrAcc, SelA=00.
  - 00011 LDI: WrAcc, SelA=01.
  - 00100 ADD: RdRam, WrAcc, SelA=10, SelB=0, Op=00.
  - 00101 ADDI: WrAcc, SelA=10, SelB=1, Op=00.
  - 00110 SUB / 00111 SUBI: same as ADD / ADDI, with Op=01.
  - 01100 AND / 01101 ANDI: same as ADD / ADDI, with Op=10.
  - 01110 OR / 01111 ORI: same as ADD / ADDI, with Op=11.
  - 01000 BEQ: branch if Zero=1.
  - 01001 BNE: branch if Zero=0.
  - 01010 BLT: branch if Neg=1.
  - 01011 JMP: branch unconditionally.
  - All other opcodes are illegal.
- Next PC: if the branch is taken, Addr <= Operand[ADDR_W-1:0]; otherwise Addr <= Addr+1, modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- HLT: Addr holds at the HLT address. Halted=1 from the next cycle. HLT counts as retired.
- RetCount increments by 1 per executed instruction, including HLT and illegal opcodes; it wraps at 2^CNT_W.
- Illegal opcode: IllegalOp <= 1 (sticky until Reset). The rest depends on the optional feature.
- Reset asserted mid-execution overrides everything: the instruction in that cycle has no effect and no strobes.

Optional Feature:
Macro BIP_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode behaves like HLT. State goes to HALT, Addr holds, Halted=1.
- Undefined: an illegal opcode is a NOP with no strobes, and Addr <= Addr+1.
- IllegalOp is set in both builds.

Test Plan:
1. Program sequence: ADD 1, STO 2, LDI 3, ADD 4, SUBI 5, ADDI 6, ADD 7, HLT, with InstrValid=1.
   -> Addr steps 0..7. The STO cycle has WrRam=1 and all other strobes 0. SUBI gives SelA=10, SelB=1, Op=01, WrAcc=1.
   -> After HLT: Addr=7, Halted=1, RetCount=8.
2. Branch tests at Addr=3:
   - BEQ 0x040 with Zero=1 -> Addr=0x040.
   - The same instruction with Zero=0 -> Addr=4.
   - BLT with Neg=1 -> taken.
   - JMP 0x7FF -> Addr=0x7FF; the next sequential instruction then wraps Addr to 0.
3. Hold InstrValid=0 for 3 cycles mid-program -> Addr and RetCount are frozen and all strobes are 0. Execution resumes unchanged when InstrValid returns to 1.
4. Opcode 11111 at Addr=8 -> IllegalOp=1.
   - Without BIP_ILLEGAL_TRAP_EN: Addr=9, Halted=0.
   - With BIP_ILLEGAL_TRAP_EN: Addr=8, Halted=1.
5. Assert Reset while in HALT and also mid-program -> next cycle Addr=0, Halted=0, IllegalOp=0, RetCount=0. No strobes are asserted during the Reset cycle.
6. Parameter build INSTR_W=24, OPC_W=5, ADDR_W=16 -> JMP 0xFFFF then a sequential step wraps Addr to 0. LDI passes the 19-bit Operand through unchanged.

Source files
------------

// File: rtl/bip_control_unit.sv
// bip_control_unit: program counter, fetch handshake and extended-ISA decode
// for the BIP accumulator core, with halt, illegal-opcode flag and a
// retired-instruction counter.
// Optional build macro BIP_ILLEGAL_TRAP_EN: when defined, an illegal opcode
// halts the core like HLT; when undefined it is a NOP that advances the PC.
module bip_control_unit #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [INSTR_W-1:0]       Instruction,
  input  logic                     InstrValid,
  input  logic                     Zero,
  input  logic                     Neg,
  output logic [ADDR_W-1:0]        Addr,
  output logic [INSTR_W-OPC_W-1:0] Operand,
  output logic [1:0]               SelA,
  output logic                     SelB,
  output logic [1:0]               Op,
  output logic                     WrAcc,
  output logic                     WrRam,
  output logic                     RdRam,
  output logic                     Halted,
  output logic                     IllegalOp,
  output logic [CNT_W-1:0]         RetCount
);

  localparam int unsigned OPR_W = INSTR_W - OPC_W;

  localparam logic [OPC_W-1:0] OPC_HLT  = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OPC_STO  = OPC_W'(5'b00001);
  localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OPC_SUBI = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OPC_BEQ  = OPC_W'(5'b01000);
  localparam logic [OPC_W-1:0] OPC_BNE  = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OPC_BLT  = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OPC_JMP  = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OPC_ANDI = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OPC_OR   = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OPC_ORI  = OPC_W'(5'b01111);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                ill_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [OPC_W-1:0]    opc;
  logic                taken;
  logic                exec;

  // Field split of the fetched word
  assign opc     = Instruction[INSTR_W-1 -: OPC_W];
  assign Operand = Instruction[OPR_W-1:0];
  assign Halted  = (state_q == S_HALT);
  assign exec    = !Reset && (state_q == S_RUN) && InstrValid;

  // Decode, next PC, next state and counter update
  always_comb begin
    state_d = state_q;
    addr_d  = Addr;
    ill_d   = IllegalOp;
    cnt_d   = RetCount;
    SelA    = 2'b00;
    SelB    = 1'b0;
    Op      = 2'b00;
    WrAcc   = 1'b0;
    WrRam   = 1'b0;
    RdRam   = 1'b0;
    taken   = 1'b0;
    if (exec) begin
      cnt_d  = RetCount + CNT_W'(1);
      addr_d = Addr + ADDR_W'(1);
      case (opc)
        OPC_HLT: begin
          state_d = S_HALT;
          addr_d  = Addr;
        end
        OPC_STO: WrRam = 1'b1;
        OPC_LD: begin
          RdRam = 1'b1;
          WrAcc = 1'b1;
        end
        OPC_LDI: begin
          WrAcc = 1'b1;
          SelA  = 2'b01;
        end
        // ALU op encoded by opcode bits 3 and 1 (add/sub/and/or)
        OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
          RdRam = 1'b1;
          WrAcc = 1'b1;
          SelA  = 2'b10;
          Op    = {opc[3], opc[1]};
        end
        OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORI: begin
          WrAcc = 1'b1;
          SelA  = 2'b10;
          SelB  = 1'b1;
          Op    = {opc[3], opc[1]};
        end
        OPC_BEQ: taken = Zero;
        OPC_BNE: taken = !Zero;
        OPC_BLT: taken = Neg;
        OPC_JMP: taken = 1'b1;
        default: begin
          ill_d = 1'b1;
`ifdef BIP_ILLEGAL_TRAP_EN
          state_d = S_HALT;
          addr_d  = Addr;
`endif
        end
      endcase
      if (taken) begin
        addr_d = Operand[ADDR_W-1:0];
      end
    end
  end

  // State, PC, sticky flag and retired counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_RUN;
      Addr      <= '0;
      IllegalOp <= 1'b0;
      RetCount  <= '0;
    end else begin
      state_q   <= state_d;
      Addr      <= addr_d;
      IllegalOp <= ill_d;
      RetCount  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: scoreboard bench for bip_control_unit (default and wide builds).
module tb_bip_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, valid, zero, neg;
  logic [15:0] instr;
  logic [10:0] addr;
  logic [10:0] operand;
  logic [1:0]  sela, op;
  logic        selb, wracc, wrram, rdram, halted, illegalop;
  logic [15:0] retcount;

  bip_control_unit u_dut (
    .Clk(clk), .Reset(rst), .Instruction(instr), .InstrValid(valid),
    .Zero(zero), .Neg(neg), .Addr(addr), .Operand(operand), .SelA(sela),
    .SelB(selb), .Op(op), .WrAcc(wracc), .WrRam(wrram), .RdRam(rdram),
    .Halted(halted), .IllegalOp(illegalop), .RetCount(retcount)
  );

  // Wide-parameter instance
  logic        rst_w, valid_w;
  logic [23:0] instr_w;
  logic [15:0] addr_w;
  logic [18:0] operand_w;
  logic [1:0]  sela_w, op_w;
  logic        selb_w, wracc_w, wrram_w, rdram_w, halted_w, illegalop_w;
  logic [15:0] retcount_w;

  bip_control_unit #(.INSTR_W(24), .OPC_W(5), .ADDR_W(16), .CNT_W(16)) u_dut_w (
    .Clk(clk), .Reset(rst_w), .Instruction(instr_w), .InstrValid(valid_w),
    .Zero(1'b0), .Neg(1'b0), .Addr(addr_w), .Operand(operand_w), .SelA(sela_w),
    .SelB(selb_w), .Op(op_w), .WrAcc(wracc_w), .WrRam(wrram_w), .RdRam(rdram_w),
    .Halted(halted_w), .IllegalOp(illegalop_w), .RetCount(retcount_w)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic        halt;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m;
  int          errors = 0;
  int          checks = 0;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] opc, input logic [10:0] opr);
    return {opc, opr};
  endfunction

  // Expected {SelA, SelB, Op, WrAcc, WrRam, RdRam} for an executed opcode
  function automatic logic [7:0] ctrl_of(input logic [4:0] opc);
    case (opc)
      5'h01:   return 8'b00_0_00_010;
      5'h02:   return 8'b00_0_00_101;
      5'h03:   return 8'b01_0_00_100;
      5'h04:   return 8'b10_0_00_101;
      5'h05:   return 8'b10_1_00_100;
      5'h06:   return 8'b10_0_01_101;
      5'h07:   return 8'b10_1_01_100;
      5'h0C:   return 8'b10_0_10_101;
      5'h0D:   return 8'b10_1_10_100;
      5'h0E:   return 8'b10_0_11_101;
      5'h0F:   return 8'b10_1_11_100;
      default: return 8'h00;
    endcase
  endfunction

  // One clock of stimulus: check decode now, queue expected registers, check after edge
  task automatic step(input logic [15:0] ins, input logic v, input logic z,
                      input logic n, input logic r);
    logic [4:0]  opc;
    logic [7:0]  ectrl;
    exp_t        nx;
    exp_t        got;
    @(negedge clk);
    instr = ins; valid = v; zero = z; neg = n; rst = r;
    opc = ins[15:11];
    #1;
    ectrl = (r || m.halt || !v) ? 8'h00 : ctrl_of(opc);
    check("ctrl", 32'({sela, selb, op, wracc, wrram, rdram}), 32'(ectrl));
    check("operand", 32'(operand), 32'(ins[10:0]));
    nx = m;
    if (r) begin
      nx = '0;
    end else if (!m.halt && v) begin
      nx.cnt  = m.cnt + 16'd1;
      nx.addr = m.addr + 11'd1;
      case (opc)
        5'h00: begin nx.halt = 1'b1; nx.addr = m.addr; end
        5'h08: if (z)  nx.addr = ins[10:0];
        5'h09: if (!z) nx.addr = ins[10:0];
        5'h0A: if (n)  nx.addr = ins[10:0];
        5'h0B: nx.addr = ins[10:0];
        default: begin
          if (opc > 5'h0F) begin
            nx.ill = 1'b1;
`ifdef BIP_ILLEGAL_TRAP_EN
            nx.halt = 1'b1;
            nx.addr = m.addr;
`endif
          end
        end
      endcase
    end
    m = nx;
    exp_q.push_back(nx);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      check("addr", 32'(addr), 32'(got.addr));
      check("halted", 32'(halted), 32'(got.halt));
      check("illegal", 32'(illegalop), 32'(got.ill));
      check("retcount", 32'(retcount), 32'(got.cnt));
    end
  endtask

  task automatic do_reset();
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ldi_n(input int n);
    for (int i = 0; i < n; i++) step(mk(5'h03, 11'(i + 1)), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; zero = 1'b0; neg = 1'b0; instr = '0;
    rst_w = 1'b1; valid_w = 1'b0; instr_w = '0;
    m = '0;

    // Reset state and the sample program
    do_reset();
    step(mk(5'h04, 11'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h01, 11'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h03, 11'd3), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h04, 11'd4), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h07, 11'd5), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h05, 11'd6), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h04, 11'd7), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h00, 11'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    check("prog_end_addr", 32'(addr), 32'd7);
    check("prog_end_cnt", 32'(retcount), 32'd8);
    // Halt ignores further instructions
    step(mk(5'h01, 11'd9), 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset while halted
    do_reset();

    // Remaining ALU and load opcodes
    step(mk(5'h02, 11'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h06, 11'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h0C, 11'd3), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h0D, 11'd4), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h0E, 11'd5), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h0F, 11'd6), 1'b1, 1'b0, 1'b0, 1'b0);

    // Branches at address 3
    do_reset(); ldi_n(3);
    step(mk(5'h08, 11'h040), 1'b1, 1'b1, 1'b0, 1'b0);
    check("beq_taken", 32'(addr), 32'h040);
    do_reset(); ldi_n(3);
    step(mk(5'h08, 11'h040), 1'b1, 1'b0, 1'b0, 1'b0);
    check("beq_not_taken", 32'(addr), 32'd4);
    step(mk(5'h09, 11'h123), 1'b1, 1'b1, 1'b0, 1'b0);
    step(mk(5'h09, 11'h123), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h0A, 11'h055), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h0A, 11'h055), 1'b1, 1'b0, 1'b1, 1'b0);
    check("blt_taken", 32'(addr), 32'h055);
    step(mk(5'h0B, 11'h7FF), 1'b1, 1'b0, 1'b0, 1'b0);
    check("jmp_top", 32'(addr), 32'h7FF);
    step(mk(5'h03, 11'h001), 1'b1, 1'b0, 1'b0, 1'b0);
    check("pc_wrap", 32'(addr), 32'd0);

    // Fetch stalls mid-program
    ldi_n(2);
    for (int i = 0; i < 3; i++) step(mk(5'h04, 11'd9), 1'b0, 1'b0, 1'b0, 1'b0);
    ldi_n(2);

    // Reset mid-program with a store presented
    step(mk(5'h01, 11'd3), 1'b1, 1'b0, 1'b0, 1'b1);
    ldi_n(8);
    // Illegal opcode at address 8
    step(mk(5'h1F, 11'd0), 1'b1, 1'b0, 1'b0, 1'b0);
    check("illegal_flag", 32'(illegalop), 32'd1);
`ifdef BIP_ILLEGAL_TRAP_EN
    check("illegal_addr", 32'(addr), 32'd8);
`else
    check("illegal_addr", 32'(addr), 32'd9);
`endif
    step(mk(5'h03, 11'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(5'h10, 11'd1), 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Wide build: 16-bit PC wrap and 19-bit operand passthrough
    @(negedge clk); rst_w = 1'b1; valid_w = 1'b0;
    @(posedge clk); #1;
    check("w_reset_addr", 32'(addr_w), 32'd0);
    @(negedge clk); rst_w = 1'b0; valid_w = 1'b1; instr_w = {5'b01011, 19'h0FFFF};
    @(posedge clk); #1;
    check("w_jmp_addr", 32'(addr_w), 32'hFFFF);
    @(negedge clk); instr_w = {5'b00011, 19'h5A5A5};
    #1;
    check("w_operand", 32'(operand_w), 32'h5A5A5);
    check("w_ldi_ctrl", 32'({sela_w, selb_w, op_w, wracc_w, wrram_w, rdram_w}), 32'h44);
    @(posedge clk); #1;
    check("w_wrap_addr", 32'(addr_w), 32'd0);
    check("w_retcount", 32'(retcount_w), 32'd2);
    check("w_halted", 32'(halted_w), 32'd0);
    valid_w = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
